// File: rtl/fifo_rd_stream_adapter_if.sv
// Handshake bundle between the FIFO read port, the adapter and the downstream stream.
// The slave modport is the adapter's view; master is the environment driving it.
interface fifo_rd_stream_adapter_if #(
    parameter int unsigned DAT_WIDTH = 17,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 fifo_empty;
    logic [DAT_WIDTH-1:0] fifo_rd_data;
    logic                 fifo_rd_op;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [DAT_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] word_cnt;
    logic                 underrun_err;

    modport slave (
        input  fifo_empty, fifo_rd_data, flush, out_ready,
        output fifo_rd_op, out_valid, out_data, word_cnt, underrun_err
    );

    modport master (
        output fifo_empty, fifo_rd_data, flush, out_ready,
        input  fifo_rd_op, out_valid, out_data, word_cnt, underrun_err
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Turns a FIFO read port with one-cycle RAM latency into a valid/ready stream
// using a 2-entry skid buffer and a single in-flight pop tracker.
module fifo_rd_stream_adapter #(
    parameter int unsigned DAT_WIDTH = 17,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                      rd_clk,
    input  logic                      rd_reset,
    fifo_rd_stream_adapter_if.slave   bus
);
    logic [1:0]           occ;
    logic                 inflight;
    logic [DAT_WIDTH-1:0] head_q;
    logic [DAT_WIDTH-1:0] tail_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 err_q;

    logic                 pop_raw;
    logic                 pop;
    logic                 capture;
    logic [2:0]           pending;
    logic                 rd_op;

    // A pop is only issued when the word it returns is guaranteed a buffer slot.
    always_comb begin
        pop_raw = (occ != 2'd0) && bus.out_ready;
        pop     = pop_raw && !bus.flush;
        capture = inflight && !bus.flush;
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop_raw};
        rd_op   = !rd_reset && !bus.fifo_empty && !bus.flush && (pending < 3'd2);
    end

    always_ff @(posedge rd_clk or posedge rd_reset) begin
        if (rd_reset) begin
            occ      <= '0;
            inflight <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            inflight <= rd_op;
            err_q    <= err_q | (rd_op & bus.fifo_empty);
            if (pop) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (bus.flush) begin
                occ <= '0;
            end else begin
                case ({capture, pop})
                    2'b10: begin
                        if (occ == 2'd0) begin
                            head_q <= bus.fifo_rd_data;
                        end else begin
                            tail_q <= bus.fifo_rd_data;
                        end
                        occ <= occ + 2'd1;
                    end
                    2'b01: begin
                        head_q <= tail_q;
                        occ    <= occ - 2'd1;
                    end
                    // Simultaneous capture and pop: occupancy holds, head advances.
                    2'b11: begin
                        if (occ == 2'd1) begin
                            head_q <= bus.fifo_rd_data;
                        end else begin
                            head_q <= tail_q;
                            tail_q <= bus.fifo_rd_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.fifo_rd_op   = rd_op;
    assign bus.out_valid    = (occ != 2'd0);
    assign bus.out_data     = head_q;
    assign bus.word_cnt     = cnt_q;
    assign bus.underrun_err = err_q;
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench for fifo_rd_stream_adapter: behavioural FIFO with one-cycle read
// latency on the read side, accepted stream words collected for in-order checks.
module tb_fifo_rd_stream_adapter;
    localparam int unsigned DW = 17;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic rd_reset;

    fifo_rd_stream_adapter_if #(.DAT_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fifo_rd_stream_adapter #(.DAT_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .rd_clk   (clk),
        .rd_reset (rd_reset),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] rx[$];
    int            checks = 0;
    int            errors = 0;
    int            op_cnt = 0;
    logic          last_op;
    logic          last_valid;
    logic [15:0]   op_bits;
    logic [15:0]   val_bits;
    logic [DW-1:0] w[0:5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        fq.push_back(d);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: sample the cycle's outputs at negedge, then model the FIFO RAM read.
    task automatic tick();
        @(negedge clk);
        last_op    = bus.fifo_rd_op;
        last_valid = bus.out_valid;
        if (last_op) op_cnt++;
        if (bus.out_valid && bus.out_ready && !bus.flush && !rd_reset) rx.push_back(bus.out_data);
        @(posedge clk);
        #1;
        if (last_op && fq.size() != 0) bus.fifo_rd_data = fq.pop_front();
        bus.fifo_empty = (fq.size() == 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rd_reset         = 1'b1;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = '0;
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_data", {15'b0, bus.out_data}, 32'd0);
        chk("rst_cnt", {16'b0, bus.word_cnt}, 32'd0);
        chk("rst_err", {31'b0, bus.underrun_err}, 32'd0);
        chk("rst_op", {31'b0, bus.fifo_rd_op}, 32'd0);
        rd_reset = 1'b0;
        tick();

        // Three words, downstream always ready.
        bus.out_ready = 1'b1;
        push(17'h0AAAA); push(17'h15555); push(17'h1C3C3);
        op_bits = '0; val_bits = '0;
        for (int c = 0; c < 7; c++) begin
            tick();
            op_bits[c]  = last_op;
            val_bits[c] = last_valid;
        end
        chk("abc_op_pattern", {16'b0, op_bits}, 32'h0007);
        chk("abc_valid_pattern", {16'b0, val_bits}, 32'h001C);
        chk("abc_size", rx.size(), 32'd3);
        chk("abc_a", {15'b0, rx[0]}, 32'h0AAAA);
        chk("abc_b", {15'b0, rx[1]}, 32'h15555);
        chk("abc_c", {15'b0, rx[2]}, 32'h1C3C3);
        chk("abc_cnt", {16'b0, bus.word_cnt}, 32'd3);

        // Five words with downstream stalled: buffer fills to two and pops stop.
        bus.out_ready = 1'b0;
        rx.delete();
        op_cnt = 0;
        w[0] = 17'h00011; w[1] = 17'h10022; w[2] = 17'h00033; w[3] = 17'h1F044; w[4] = 17'h00F55;
        for (int i = 0; i < 5; i++) push(w[i]);
        for (int i = 0; i < 6; i++) tick();
        chk("stall_pops", op_cnt, 32'd2);
        chk("stall_op_low", {31'b0, bus.fifo_rd_op}, 32'd0);
        chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("stall_head", {15'b0, bus.out_data}, 32'h00011);
        chk("stall_fifo_left", fq.size(), 32'd3);
        for (int i = 0; i < 3; i++) tick();
        chk("stall_head_hold", {15'b0, bus.out_data}, 32'h00011);
        chk("stall_pops_hold", op_cnt, 32'd2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && rx.size() < 5; i++) tick();
        chk("stall_rx_size", rx.size(), 32'd5);
        for (int i = 0; i < 5; i++) chk("stall_order", {15'b0, rx[i]}, {15'b0, w[i]});
        chk("stall_cnt", {16'b0, bus.word_cnt}, 32'd8);
        tick(); tick();

        // Flush with occ=1 and one word in flight.
        bus.out_ready = 1'b0;
        rx.delete();
        push(17'h01234);
        tick();
        tick();
        push(17'h05678); push(17'h09ABC);
        tick();
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_op_forced_low", {31'b0, bus.fifo_rd_op}, 32'd0);
        tick();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("flush_valid_low", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_cnt_same", {16'b0, bus.word_cnt}, 32'd8);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("flush_rx_size", rx.size(), 32'd1);
        chk("flush_survivor", {15'b0, rx[0]}, 32'h09ABC);
        chk("flush_cnt_after", {16'b0, bus.word_cnt}, 32'd9);

        // Counter wrap: 65526 more pops reach 0xFFFF, one more wraps to zero.
        rx.delete();
        for (int i = 0; i < 65526; i++) push(DW'(i));
        for (int i = 0; i < 70000 && bus.word_cnt != 16'hFFFF; i++) tick();
        tick(); tick(); tick();
        chk("wrap_max", {16'b0, bus.word_cnt}, 32'h0000FFFF);
        chk("wrap_rx_size", rx.size(), 32'd65526);
        chk("wrap_drained", {31'b0, bus.out_valid}, 32'd0);
        rx.delete();
        push(17'h1ABCD);
        for (int i = 0; i < 4; i++) tick();
        chk("wrap_zero", {16'b0, bus.word_cnt}, 32'd0);
        chk("wrap_word", {15'b0, rx[0]}, 32'h1ABCD);

        // Toggling ready every cycle.
        rx.delete();
        w[0] = 17'h00101; w[1] = 17'h10202; w[2] = 17'h00303; w[3] = 17'h10404; w[4] = 17'h00505; w[5] = 17'h10606;
        for (int i = 0; i < 6; i++) push(w[i]);
        for (int i = 0; i < 30; i++) begin
            tick();
            bus.out_ready = !bus.out_ready;
        end
        chk("toggle_rx_size", rx.size(), 32'd6);
        for (int i = 0; i < 6; i++) chk("toggle_order", {15'b0, rx[i]}, {15'b0, w[i]});
        chk("toggle_cnt", {16'b0, bus.word_cnt}, 32'd6);
        chk("toggle_err", {31'b0, bus.underrun_err}, 32'd0);

        // Asynchronous reset mid-stream with the buffer full.
        bus.out_ready = 1'b0;
        rx.delete();
        push(17'h0C001); push(17'h0C002); push(17'h0C003);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("pre_rst_head", {15'b0, bus.out_data}, 32'h0C001);
        #2;
        rd_reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("async_rst_cnt", {16'b0, bus.word_cnt}, 32'd0);
        chk("async_rst_data", {15'b0, bus.out_data}, 32'd0);
        chk("async_rst_op", {31'b0, bus.fifo_rd_op}, 32'd0);
        tick();
        rd_reset      = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_rx_size", rx.size(), 32'd1);
        chk("post_rst_word", {15'b0, rx[0]}, 32'h0C003);
        chk("post_rst_cnt", {16'b0, bus.word_cnt}, 32'd1);
        chk("final_err", {31'b0, bus.underrun_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
